id_ex_fwd_reg: RTL and testbench

- ID/EX pipeline register that feeds the EX-stage operand forwarding muxes.
- Captures decoded operands each cycle and pre-computes the 2-bit forwarding selects one cycle early, so EX sees registered selects. Encoding: 00 = regfile, 01 = WB, 10 = MEM.
- Also performs load-use stall detection, inserts bubbles on stall or flush, and bypasses the same-cycle WB write into the captured operand.

---
 rtl/id_ex_fwd_reg.sv | 128 ++++++++++++
 tb/tb_id_ex_fwd_reg.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_fwd_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_fwd_reg
// Purpose  : ID/EX pipeline register with registered forwarding selects,
//            load-use stall detection, bubble insertion and WB bypass.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_fwd_reg #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [REGW-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [REGW-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            stall_id,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [1:0]      ex_fwd_a,
    output logic [1:0]      ex_fwd_b,
    output logic [CNTW-1:0] bubble_cnt
);

    localparam logic [1:0] c_SEL_RF  = 2'b00;
    localparam logic [1:0] c_SEL_WB  = 2'b01;
    localparam logic [1:0] c_SEL_MEM = 2'b10;

    logic            w_bubble;
    logic [1:0]      w_sel_a;
    logic [1:0]      w_sel_b;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;

    // Newest producer wins; x0 never forwards. A WB hit is folded into the
    // captured operand so EX only needs the regfile path for select 00.
    function automatic logic [XLEN+1:0] resolve(input logic [REGW-1:0] rs,
                                                 input logic [XLEN-1:0] rf);
        logic [1:0]      sel;
        logic [XLEN-1:0] op;
        sel = c_SEL_RF;
        op  = rf;
        if (rs == '0) begin
            sel = c_SEL_RF;
        end else if (ex_valid && ex_reg_write && (ex_rd == rs)) begin
            sel = c_SEL_MEM;
        end else if (mem_reg_write && (mem_rd == rs)) begin
            sel = c_SEL_WB;
        end else if (wb_reg_write && (wb_rd == rs)) begin
            op = wb_data;
        end
        if (!id_valid) begin
            sel = c_SEL_RF;
        end
        return {sel, op};
    endfunction

    always_comb begin
        stall_id = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && !flush;
        w_bubble = flush || stall_id;
        {w_sel_a, w_op_a} = resolve(id_rs1, id_rd1);
        {w_sel_b, w_op_b} = resolve(id_rs2, id_rd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_fwd_a     <= c_SEL_RF;
            ex_fwd_b     <= c_SEL_RF;
        end else if (w_bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_fwd_a     <= c_SEL_RF;
            ex_fwd_b     <= c_SEL_RF;
        end else begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_valid && id_reg_write;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_op_a      <= w_op_a;
            ex_op_b      <= w_op_b;
            ex_fwd_a     <= w_sel_a;
            ex_fwd_b     <= w_sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (w_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_fwd_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_fwd_reg
// Purpose  : Directed plus random self-checking bench for id_ex_fwd_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_fwd_reg;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst, id_valid, id_reg_write, id_mem_read;
    logic [REGW-1:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic [XLEN-1:0] id_rd1, id_rd2, wb_data;
    logic            mem_reg_write, wb_reg_write, flush;
    logic            stall_id, ex_valid, ex_reg_write, ex_mem_read;
    logic [REGW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0] ex_op_a, ex_op_b;
    logic [1:0]      ex_fwd_a, ex_fwd_b;
    logic [CNTW-1:0] bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what EX should hold after the last edge.
    bit      m_init = 0;
    bit      m_valid, m_rw, m_mr, m_ctl_known;
    int      m_rs1, m_rs2, m_rd, m_fa, m_fb, m_cnt;
    longint  m_opa, m_opb;

    always #5 clk = ~clk;

    id_ex_fwd_reg #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_rd1(id_rd1), .id_rd2(id_rd2),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Producers listed newest first; the first matching one decides the select.
    task automatic model_fwd(input int rs, input longint rf,
                             output int sel, output longint op);
        int     p_rd [3];
        bit     p_en [3];
        int     p_sel[3];
        sel = 0;
        op  = rf;
        p_en[0] = m_valid && m_rw;  p_rd[0] = m_rd;         p_sel[0] = 2;
        p_en[1] = mem_reg_write;    p_rd[1] = int'(mem_rd); p_sel[1] = 1;
        p_en[2] = wb_reg_write;     p_rd[2] = int'(wb_rd);  p_sel[2] = 0;
        if (rs != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (p_en[k] && p_rd[k] == rs) begin
                    sel = p_sel[k];
                    if (k == 2) op = longint'(wb_data);
                    break;
                end
            end
        end
        if (!id_valid) sel = 0;
    endtask

    task automatic idle_inputs();
        rst = 0; id_valid = 0; id_reg_write = 0; id_mem_read = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd1 = 0; id_rd2 = 0;
        mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
        wb_data = 0; flush = 0;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd,
                         input bit rw, input bit mr);
        id_valid = 1; id_rs1 = REGW'(rs1); id_rs2 = REGW'(rs2); id_rd = REGW'(rd);
        id_reg_write = rw; id_mem_read = mr;
        id_rd1 = $urandom; id_rd2 = $urandom;
    endtask

    // Check the combinational stall, advance one edge, check registered state.
    task automatic cycle();
        bit     e_stall;
        int     sa, sb;
        longint oa, ob;
        #1;
        e_stall = id_valid && m_valid && m_mr && m_rd != 0 &&
                  (m_rd == int'(id_rs1) || m_rd == int'(id_rs2)) && !flush;
        if (m_init) chk("stall_id", stall_id, e_stall);
        model_fwd(int'(id_rs1), longint'(id_rd1), sa, oa);
        model_fwd(int'(id_rs2), longint'(id_rd2), sb, ob);
        if (rst) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
            m_fa = 0; m_fb = 0; m_opa = 0; m_opb = 0; m_cnt = 0; m_ctl_known = 1;
        end else if (flush || e_stall) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_rd = 0; m_fa = 0; m_fb = 0;
            m_ctl_known = 1;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else begin
            m_valid = id_valid; m_rw = id_valid && id_reg_write;
            m_mr = id_valid && id_mem_read; m_ctl_known = id_valid;
            m_rs1 = int'(id_rs1); m_rs2 = int'(id_rs2); m_rd = int'(id_rd);
            m_fa = sa; m_fb = sb; m_opa = oa; m_opb = ob;
        end
        @(posedge clk);
        #1;
        if (rst) m_init = 1;
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_fwd_a", ex_fwd_a, m_fa);
        chk("ex_fwd_b", ex_fwd_b, m_fb);
        chk("bubble_cnt", bubble_cnt, m_cnt);
        if (m_ctl_known) begin
            chk("ex_reg_write", ex_reg_write, m_rw);
            chk("ex_mem_read", ex_mem_read, m_mr);
            chk("ex_rd", ex_rd, m_rd);
        end
        if (m_valid) begin
            chk("ex_rs1", ex_rs1, m_rs1);
            chk("ex_rs2", ex_rs2, m_rs2);
            if (m_fa == 0) chk("ex_op_a", ex_op_a, m_opa);
            if (m_fb == 0) chk("ex_op_b", ex_op_b, m_opb);
        end
    endtask

    initial begin
        // Reset held for two edges with a live instruction in ID
        idle_inputs();
        rst = 1;
        issue(1, 2, 3, 1, 0);
        cycle();
        cycle();
        chk("rst_valid", ex_valid, 0);
        chk("rst_cnt", bubble_cnt, 0);
        rst = 0;
        issue(1, 2, 4, 1, 0);
        cycle();
        chk("rel_capture", ex_rd, 4);

        // EX->EX forward on both sources
        issue(1, 2, 5, 1, 0);
        cycle();
        issue(5, 5, 6, 0, 0);
        cycle();
        chk("ex2ex_a", ex_fwd_a, 2'b10);
        chk("ex2ex_b", ex_fwd_b, 2'b10);

        // EX beats MEM; then MEM wins once EX does not write
        issue(1, 2, 7, 1, 0);
        cycle();
        mem_rd = 7; mem_reg_write = 1;
        issue(7, 1, 8, 0, 0);
        cycle();
        chk("prio_ex", ex_fwd_a, 2'b10);
        issue(7, 1, 0, 0, 0);
        cycle();
        chk("mem_fwd", ex_fwd_a, 2'b01);
        mem_reg_write = 0; mem_rd = 0;

        // WB write-through bypass into operand b
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
        issue(1, 3, 0, 0, 0);
        id_rd2 = 0;
        cycle();
        chk("wb_sel", ex_fwd_b, 2'b00);
        chk("wb_op", ex_op_b, 32'hDEADBEEF);
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;

        // Load-use: one stall cycle, one bubble, then capture with sel=01
        issue(1, 2, 9, 1, 1);
        cycle();
        issue(9, 2, 10, 1, 0);
        #1;
        chk("lu_stall", stall_id, 1);
        cycle();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_cnt", bubble_cnt, 1);
        mem_rd = 9; mem_reg_write = 1;
        #1;
        chk("lu_nostall", stall_id, 0);
        cycle();
        chk("lu_fwd", ex_fwd_a, 2'b01);
        mem_reg_write = 0; mem_rd = 0;

        // Flush during a load-use match wins over the stall
        issue(1, 2, 9, 1, 1);
        cycle();
        issue(9, 2, 11, 1, 0);
        flush = 1;
        #1;
        chk("flush_stall", stall_id, 0);
        cycle();
        flush = 0;
        chk("flush_bubble", ex_valid, 0);
        chk("flush_cnt", bubble_cnt, 2);

        // x0 never forwards even with writers to x0 everywhere
        issue(1, 2, 0, 1, 0);
        cycle();
        mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1;
        issue(0, 0, 12, 0, 0);
        cycle();
        chk("x0_fwd", ex_fwd_a, 2'b00);
        mem_reg_write = 0; wb_reg_write = 0;

        // Invalid ID slot: no bubble counted
        idle_inputs();
        cycle();
        chk("idle_cnt", bubble_cnt, 2);

        // Saturation of the bubble counter
        flush = 1;
        for (int i = 0; i < CMAX + 4; i++) cycle();
        chk("sat_cnt", bubble_cnt, CMAX);
        flush = 0;

        // Randomised traffic over a small register window to force hits
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 59) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            issue($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), ($urandom_range(0, 2) == 0));
            id_valid      = ($urandom_range(0, 5) != 0);
            mem_rd        = REGW'($urandom_range(0, 3));
            mem_reg_write = $urandom_range(0, 1);
            wb_rd         = REGW'($urandom_range(0, 3));
            wb_reg_write  = $urandom_range(0, 1);
            wb_data       = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
